// File: rtl/simple_cpu_top.sv
// 16-bit multi-cycle teaching CPU: synchronous instruction ROM plus a fetch/decode/execute core
// with four general registers and a 12-bit program counter.

module sync_rom #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AWIDTH-1:0] i_addr,
    output logic [DWIDTH-1:0] o_data
);
    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];
    logic [DWIDTH-1:0] r_data;

    // Contents are normally loaded from outside; the write port exists for preloading.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        r_data <= mem[i_addr];
    end

    assign o_data = r_data;
endmodule

module irom #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic [AWIDTH-1:0] i_addr,
    output logic [DWIDTH-1:0] o_data
);
    sync_rom #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) sync_rom_i (
        .clk     (clk),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata ('0),
        .i_addr  (i_addr),
        .o_data  (o_data)
    );
endmodule

module reg_cell #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [DWIDTH-1:0] i_d,
    output logic [DWIDTH-1:0] o_q
);
    logic [DWIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (i_we) begin
            q <= i_d;
        end
    end

    assign o_q = q;
endmodule

module reg_group #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [1:0]        i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] q0,
    output logic [DWIDTH-1:0] q1,
    output logic [DWIDTH-1:0] q2,
    output logic [DWIDTH-1:0] q3
);
    logic [3:0] w_we;

    assign w_we = i_we ? (4'b0001 << i_waddr) : 4'b0000;

    reg_cell #(.DWIDTH(DWIDTH)) x0 (.clk(clk), .rst_n(rst_n), .i_we(w_we[0]), .i_d(i_wdata), .o_q(q0));
    reg_cell #(.DWIDTH(DWIDTH)) x1 (.clk(clk), .rst_n(rst_n), .i_we(w_we[1]), .i_d(i_wdata), .o_q(q1));
    reg_cell #(.DWIDTH(DWIDTH)) x2 (.clk(clk), .rst_n(rst_n), .i_we(w_we[2]), .i_d(i_wdata), .o_q(q2));
    reg_cell #(.DWIDTH(DWIDTH)) x3 (.clk(clk), .rst_n(rst_n), .i_we(w_we[3]), .i_d(i_wdata), .o_q(q3));
endmodule

module data_path #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ld_ir,
    input  logic              i_exec,
    input  logic [DWIDTH-1:0] i_rom_data,
    output logic [AWIDTH-1:0] o_rom_addr
);
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_SUBI = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_ORI  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;

    logic [DWIDTH-1:0] r_ir;
    logic [AWIDTH-1:0] r_pc;

    logic [3:0]        w_op;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs;
    logic [7:0]        w_imm;
    logic [DWIDTH-1:0] w_regs [4];
    logic [DWIDTH-1:0] w_a;
    logic [DWIDTH-1:0] w_b;
    logic [DWIDTH-1:0] w_result;
    logic              w_wr;

    assign w_op  = r_ir[15:12];
    assign w_rd  = r_ir[11:10];
    assign w_rs  = r_ir[9:8];
    assign w_imm = r_ir[7:0];

    assign w_a  = w_regs[w_rd];
    assign w_b  = w_op[2] ? {{(DWIDTH-8){1'b0}}, w_imm} : w_regs[w_rs];
    assign w_wr = i_exec && !w_op[3];

    // The ROM address follows the PC continuously so fetch data stays stable while stalled.
    assign o_rom_addr = r_pc;

    always_comb begin
        w_result = w_a;
        case (w_op)
            OP_ADD, OP_ADDI: w_result = w_a + w_b;
            OP_SUB, OP_SUBI: w_result = w_a - w_b;
            OP_AND, OP_ANDI: w_result = w_a & w_b;
            OP_OR,  OP_ORI:  w_result = w_a | w_b;
            default:         w_result = w_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
            r_pc <= '0;
        end else begin
            if (i_ld_ir) begin
                r_ir <= i_rom_data;
            end
            if (i_exec) begin
                if (w_op == OP_JMP) begin
                    r_pc <= {{(AWIDTH-8){1'b0}}, w_imm};
                end else begin
                    r_pc <= r_pc + {{(AWIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    reg_group #(.DWIDTH(DWIDTH)) reg_group_i (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr),
        .i_waddr (w_rd),
        .i_wdata (w_result),
        .q0      (w_regs[0]),
        .q1      (w_regs[1]),
        .q2      (w_regs[2]),
        .q3      (w_regs[3])
    );
endmodule

module cpu #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DWIDTH-1:0] i_rom_data,
    output logic [AWIDTH-1:0] o_rom_addr
);
    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] DECODE  = 2'd1;
    localparam logic [1:0] EXECUTE = 2'd2;

    logic [1:0] r_state;
    logic       w_ld_ir;
    logic       w_exec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else if (i_en) begin
            case (r_state)
                FETCH:   r_state <= DECODE;
                DECODE:  r_state <= EXECUTE;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign w_ld_ir = i_en && (r_state == DECODE);
    assign w_exec  = i_en && (r_state == EXECUTE);

    data_path #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) data_path_i (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ld_ir    (w_ld_ir),
        .i_exec     (w_exec),
        .i_rom_data (i_rom_data),
        .o_rom_addr (o_rom_addr)
    );
endmodule

module simple_cpu_top #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
) (
    input logic clk,
    input logic rst_n,
    input logic en_in
);
    logic [AWIDTH-1:0] w_rom_addr;
    logic [DWIDTH-1:0] w_rom_data;

    irom #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) irom_i (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

    cpu #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) cpu_i (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en_in),
        .i_rom_data (w_rom_data),
        .o_rom_addr (w_rom_addr)
    );
endmodule

// File: tb/tb_simple_cpu_top.sv
// Scoreboard bench for simple_cpu_top: an instruction-level model predicts the architectural
// state after every instruction and a monitor compares it each time an instruction retires.

module tb_simple_cpu_top;
    typedef struct packed {
        logic [11:0] pc;
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] r3;
    } exp_t;

    logic clk;
    logic rst_n;
    logic en_in;

    logic [15:0] mRom [4096];
    logic [15:0] mRegs [4];
    logic [11:0] mPc;
    exp_t        expQ [$];
    exp_t        lastExp;
    int          phase;
    int          assertCount;
    int          failCount;

    simple_cpu_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en_in (en_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setRegs(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        dut.cpu_i.data_path_i.reg_group_i.x0.q = a;
        dut.cpu_i.data_path_i.reg_group_i.x1.q = b;
        dut.cpu_i.data_path_i.reg_group_i.x2.q = c;
        dut.cpu_i.data_path_i.reg_group_i.x3.q = d;
        mRegs[0] = a;
        mRegs[1] = b;
        mRegs[2] = c;
        mRegs[3] = d;
    endtask

    task automatic loadWord(input int addr, input logic [15:0] w);
        dut.irom_i.sync_rom_i.mem[addr] = w;
        mRom[addr] = w;
    endtask

    // Hold the core in reset, drop pending expectations and blank the ROM.
    task automatic enterReset();
        @(negedge clk);
        rst_n = 1'b0;
        en_in = 1'b1;
        expQ.delete();
        for (int i = 0; i < 4096; i++) loadWord(i, 16'h0000);
    endtask

    task automatic releaseReset(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        @(negedge clk);
        rst_n = 1'b1;
        mPc = 12'd0;
        setRegs(a, b, c, d);
        lastExp = '{pc: mPc, r0: a, r1: b, r2: c, r3: d};
    endtask

    // Instruction-set reference: one architectural instruction per call.
    task automatic modelStep();
        logic [15:0] w;
        logic [3:0]  op;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic [15:0] imm;
        w   = mRom[mPc];
        op  = w[15:12];
        rd  = w[11:10];
        rs  = w[9:8];
        imm = {8'h00, w[7:0]};
        mPc = mPc + 12'd1;
        case (op)
            4'h0: mRegs[rd] = mRegs[rd] + mRegs[rs];
            4'h1: mRegs[rd] = mRegs[rd] - mRegs[rs];
            4'h2: mRegs[rd] = mRegs[rd] & mRegs[rs];
            4'h3: mRegs[rd] = mRegs[rd] | mRegs[rs];
            4'h4: mRegs[rd] = mRegs[rd] + imm;
            4'h5: mRegs[rd] = mRegs[rd] - imm;
            4'h6: mRegs[rd] = mRegs[rd] & imm;
            4'h7: mRegs[rd] = mRegs[rd] | imm;
            4'h8: mPc = {4'h0, w[7:0]};
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            modelStep();
            expQ.push_back('{pc: mPc, r0: mRegs[0], r1: mRegs[1], r2: mRegs[2], r3: mRegs[3]});
        end
    endtask

    task automatic waitDrain(input int budget, input bit randEn);
        int n;
        n = 0;
        while (expQ.size() > 0 && n < budget) begin
            @(negedge clk);
            en_in = randEn ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        @(negedge clk);
        en_in = 1'b1;
        assertCount++;
        if (expQ.size() > 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d instructions still pending, required 0", expQ.size());
        end
    endtask

    // Every third enabled edge out of reset ends an instruction; compare right after it.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            phase = 0;
        end else if (en_in) begin
            phase++;
            if (phase == 3) begin
                phase = 0;
                #1;
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("pc", {4'h0, dut.cpu_i.data_path_i.r_pc}, {4'h0, e.pc});
                    checkOutput("x0", dut.cpu_i.data_path_i.reg_group_i.x0.q, e.r0);
                    checkOutput("x1", dut.cpu_i.data_path_i.reg_group_i.x1.q, e.r1);
                    checkOutput("x2", dut.cpu_i.data_path_i.reg_group_i.x2.q, e.r2);
                    checkOutput("x3", dut.cpu_i.data_path_i.reg_group_i.x3.q, e.r3);
                    lastExp = e;
                end
            end
        end
    end

    initial begin
        logic [15:0] w;
        assertCount = 0;
        failCount   = 0;
        phase       = 0;
        rst_n       = 1'b0;
        en_in       = 1'b1;

        enterReset();
        #1;
        checkOutput("reset pc", {4'h0, dut.cpu_i.data_path_i.r_pc}, 16'h0000);
        checkOutput("reset ir", dut.cpu_i.data_path_i.r_ir, 16'h0000);
        checkOutput("reset x1", dut.cpu_i.data_path_i.reg_group_i.x1.q, 16'h0000);
        checkOutput("reset x3", dut.cpu_i.data_path_i.reg_group_i.x3.q, 16'h0000);

        $display("[TB] immediate ops");
        enterReset();
        loadWord(0, 16'h4401);
        loadWord(1, 16'h6001);
        releaseReset(16'd0, 16'd1, 16'd4, 16'd2);
        applyStimulus(2);
        waitDrain(100, 1'b0);
        checkOutput("addi x1", dut.cpu_i.data_path_i.reg_group_i.x1.q, 16'd2);
        checkOutput("andi x0", dut.cpu_i.data_path_i.reg_group_i.x0.q, 16'd0);

        $display("[TB] add/sub wrap");
        enterReset();
        loadWord(0, 16'h0600);
        loadWord(1, 16'h1600);
        loadWord(2, 16'h1600);
        releaseReset(16'd0, 16'd1, 16'd2, 16'd0);
        applyStimulus(3);
        waitDrain(100, 1'b0);
        checkOutput("sub wrap x1", dut.cpu_i.data_path_i.reg_group_i.x1.q, 16'hFFFF);

        $display("[TB] logic ops");
        enterReset();
        loadWord(0, 16'h2B00);
        loadWord(1, 16'h3E00);
        loadWord(2, 16'h7CF0);
        releaseReset(16'd0, 16'd0, 16'd4, 16'd2);
        applyStimulus(3);
        waitDrain(100, 1'b0);
        checkOutput("and x2", dut.cpu_i.data_path_i.reg_group_i.x2.q, 16'h0000);
        checkOutput("ori x3", dut.cpu_i.data_path_i.reg_group_i.x3.q, 16'h00F2);

        $display("[TB] loop, hold and mid-run reset");
        enterReset();
        loadWord(0, 16'h4401);
        loadWord(1, 16'h8000);
        releaseReset(16'd0, 16'd0, 16'd0, 16'd0);
        applyStimulus(40);
        repeat (22) @(negedge clk);
        en_in = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("hold x1", dut.cpu_i.data_path_i.reg_group_i.x1.q, lastExp.r1);
        checkOutput("hold pc", {4'h0, dut.cpu_i.data_path_i.r_pc}, {4'h0, lastExp.pc});
        en_in = 1'b1;
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midreset x0", dut.cpu_i.data_path_i.reg_group_i.x0.q, 16'h0000);
        checkOutput("midreset x1", dut.cpu_i.data_path_i.reg_group_i.x1.q, 16'h0000);
        checkOutput("midreset x2", dut.cpu_i.data_path_i.reg_group_i.x2.q, 16'h0000);
        checkOutput("midreset x3", dut.cpu_i.data_path_i.reg_group_i.x3.q, 16'h0000);
        checkOutput("midreset pc", {4'h0, dut.cpu_i.data_path_i.r_pc}, 16'h0000);
        releaseReset(16'd0, 16'd0, 16'd0, 16'd0);
        applyStimulus(6);
        waitDrain(100, 1'b0);
        checkOutput("restart x1", dut.cpu_i.data_path_i.reg_group_i.x1.q, 16'd3);

        $display("[TB] random programs");
        for (int t = 0; t < 6; t++) begin
            enterReset();
            for (int a = 0; a < 32; a++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'h8) w[7:0] = 8'($urandom_range(0, 31));
                loadWord(a, w);
            end
            releaseReset(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            applyStimulus(60);
            waitDrain(600, 1'b1);
        end

        $display("[TB] pc wrap");
        enterReset();
        loadWord(0, 16'h4401);
        releaseReset(16'($urandom), 16'h0000, 16'($urandom), 16'($urandom));
        applyStimulus(4097);
        waitDrain(13000, 1'b0);
        checkOutput("wrap x1", dut.cpu_i.data_path_i.reg_group_i.x1.q, 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
